// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with ack timeouts and a retired-instruction counter.
// Latency 3 cycles (4 with a memory access) plus one per wait cycle; requests are held until acked or timed out.
module cpu_sequencer #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               ACK_TIMEOUT  = 255,
  parameter int               COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [XLEN-1:0]        dmem_addr,
  output logic [XLEN-1:0]        dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [XLEN-1:0]        dmem_rdata,
  input  logic                   dec_load,
  input  logic                   dec_store,
  input  logic                   dec_reg_write,
  input  logic                   dec_halt,
  input  logic [1:0]             dec_size,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        store_data,
  input  logic [XLEN-1:0]        next_pc,
  output logic [31:0]            instruction,
  output logic [XLEN-1:0]        PC,
  output logic [XLEN-1:0]        load_data,
  output logic                   rf_write_enable,
  output logic [COUNT_WIDTH-1:0] retired,
  output logic                   halted,
  output logic                   fault,
  output logic [1:0]             fault_cause
);

  typedef enum logic [2:0] {FETCH, EXECUTE, MEMORY, WRITEBACK, HALT, FAULT} state_t;

  localparam logic [31:0] WAIT_LIMIT = 32'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [31:0] wait_cnt;
  logic        mem_op;
  logic        misaligned;
  logic        timeout_hit;
  logic        pc_bad;

  assign mem_op      = dec_load | dec_store;
  assign pc_bad      = |next_pc[1:0];
  // The wait counter sits at ACK_TIMEOUT-1 during the last allowed un-acked cycle.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    misaligned = 1'b0;
    case (dec_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result[0];
      default: misaligned = |alu_result[1:0];
    endcase
  end

  assign imem_req        = !reset && (state == FETCH);
  assign imem_addr       = PC;
  assign dmem_req        = !reset && (state == MEMORY);
  assign dmem_we         = dmem_req && dec_store;
  assign dmem_addr       = alu_result;
  assign dmem_wdata      = store_data;
  assign rf_write_enable = !reset && (state == WRITEBACK) && dec_reg_write && !pc_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      PC          <= RESET_VECTOR;
      instruction <= 32'h0000_0013;
      load_data   <= '0;
      retired     <= '0;
      wait_cnt    <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            wait_cnt    <= '0;
            state       <= EXECUTE;
          end else if (timeout_hit) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b10;
          end else begin
            wait_cnt    <= wait_cnt + 32'd1;
          end
        end
        EXECUTE: begin
          if (dec_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (mem_op && misaligned) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b01;
          end else if (mem_op) begin
            wait_cnt <= '0;
            state    <= MEMORY;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEMORY: begin
          if (dmem_ack) begin
            if (dec_load) load_data <= dmem_rdata;
            state <= WRITEBACK;
          end else if (timeout_hit) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b11;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        WRITEBACK: begin
          if (pc_bad) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b01;
          end else begin
            PC       <= next_pc;
            retired  <= retired + 1'b1;
            wait_cnt <= '0;
            state    <= FETCH;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand-built reset/halt sequences and a random run against a transaction-level model.
module tb_cpu_sequencer;

  localparam int          TO = 4;
  localparam int          CW = 4;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ack = 1'b0;
  logic [31:0]   imem_addr, imem_rdata = '0;
  logic          dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic          dec_load = 1'b0, dec_store = 1'b0, dec_reg_write = 1'b0, dec_halt = 1'b0;
  logic [1:0]    dec_size = 2'b10;
  logic [31:0]   alu_result = '0, store_data = '0, next_pc = '0;
  logic [31:0]   instruction, PC, load_data;
  logic          rf_write_enable, halted, fault;
  logic [CW-1:0] retired;
  logic [1:0]    fault_cause;

  cpu_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .ACK_TIMEOUT(TO), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dec_load(dec_load), .dec_store(dec_store), .dec_reg_write(dec_reg_write), .dec_halt(dec_halt),
    .dec_size(dec_size), .alu_result(alu_result), .store_data(store_data), .next_pc(next_pc),
    .instruction(instruction), .PC(PC), .load_data(load_data), .rf_write_enable(rf_write_enable),
    .retired(retired), .halted(halted), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          iwait, dwait;
    bit          ld, st, rw, h;
    logic [1:0]  sz;
    logic [31:0] alu, sd, npc, drd, ird;
  } instr_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    int          ret;
    logic [31:0] ld;
    bit          h, f;
    logic [1:0]  cause;
    int          rfwe_cyc;
    bit          dseen, weseen;
  } exp_t;

  typedef struct {
    int          cyc, rfwe_n, rfwe_cyc;
    bit          dseen, weseen, dbus_bad, done;
    logic [31:0] faddr;
  } res_t;

  typedef struct {
    instr_t in;
    exp_t   ex;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_ld, m_ir;
  int          m_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk_ins(input int iw, input int dw, input bit ld, input bit st, input bit rw,
                                    input bit h, input logic [1:0] sz, input logic [31:0] alu,
                                    input logic [31:0] npc, input logic [31:0] drd);
    instr_t t;
    t.iwait = iw; t.dwait = dw; t.ld = ld; t.st = st; t.rw = rw; t.h = h; t.sz = sz;
    t.alu = alu; t.sd = ~alu; t.npc = npc; t.drd = drd; t.ird = alu ^ npc ^ 32'h0000_0093;
    return t;
  endfunction

  function automatic exp_t mk_exp(input int cyc, input logic [31:0] pc, input int ret, input logic [31:0] ld,
                                  input bit h, input bit f, input logic [1:0] cause, input int rfwe_cyc,
                                  input bit dseen, input bit weseen);
    exp_t e;
    e.cyc = cyc; e.pc = pc; e.ret = ret; e.ld = ld; e.h = h; e.f = f; e.cause = cause;
    e.rfwe_cyc = rfwe_cyc; e.dseen = dseen; e.weseen = weseen;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RV; m_ld = '0; m_ir = 32'h0000_0013; m_ret = 0;
  endtask

  // Outcome of one instruction from its wait counts and decode fields.
  task automatic model_step(input instr_t t, output exp_t e);
    int align;
    e.h = 0; e.f = 0; e.cause = 2'd0; e.rfwe_cyc = 0; e.dseen = 0; e.weseen = 0;
    if (t.iwait >= TO) begin
      e.cyc = TO; e.f = 1; e.cause = 2'd2;
    end else begin
      m_ir  = t.ird;
      e.cyc = t.iwait + 2;
      align = 1 << ((t.sz == 2'd3) ? 2 : int'(t.sz));
      if (t.h) e.h = 1;
      else if ((t.ld || t.st) && (int'(t.alu[7:0]) % align != 0)) begin
        e.f = 1; e.cause = 2'd1;
      end else begin
        if (t.ld || t.st) begin
          e.dseen = 1; e.weseen = t.st;
          if (t.dwait >= TO) begin
            e.cyc += TO; e.f = 1; e.cause = 2'd3;
          end else begin
            e.cyc += t.dwait + 1;
            if (t.ld) m_ld = t.drd;
          end
        end
        if (!e.f) begin
          e.cyc += 1;
          if (int'(t.npc[7:0]) % 4 != 0) begin
            e.f = 1; e.cause = 2'd1;
          end else begin
            m_pc  = t.npc;
            m_ret = (m_ret + 1) % (1 << CW);
            if (t.rw) e.rfwe_cyc = e.cyc;
          end
        end
      end
    end
    e.pc = m_pc; e.ret = m_ret; e.ld = m_ld;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = '1; dmem_rdata = '1;
    @(posedge clock); #1;
    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    model_reset();
  endtask

  // Acts as both memories: acks after the requested number of wait cycles, stray acks otherwise.
  task automatic run_instr(input instr_t t, output res_t r);
    logic [CW-1:0] r0;
    int in_n, dn_n;
    dec_load = t.ld; dec_store = t.st; dec_reg_write = t.rw; dec_halt = t.h; dec_size = t.sz;
    alu_result = t.alu; store_data = t.sd; next_pc = t.npc; imem_rdata = t.ird; dmem_rdata = t.drd;
    r.cyc = 0; r.rfwe_n = 0; r.rfwe_cyc = 0; r.dseen = 0; r.weseen = 0; r.dbus_bad = 0; r.done = 0;
    r.faddr = '0;
    r0 = retired; in_n = 0; dn_n = 0;
    for (int c = 0; c < 64 && !r.done; c++) begin
      @(negedge clock);
      if (c == 0) r.faddr = imem_addr;
      imem_ack = imem_req ? (in_n == t.iwait) : 1'($urandom_range(0, 1));
      dmem_ack = dmem_req ? (dn_n == t.dwait) : 1'($urandom_range(0, 1));
      if (imem_req) in_n++;
      if (dmem_req) begin
        dn_n++; r.dseen = 1;
        if (dmem_we) r.weseen = 1;
        if (dmem_addr !== t.alu || dmem_wdata !== t.sd) r.dbus_bad = 1;
      end
      if (rf_write_enable) begin r.rfwe_n++; r.rfwe_cyc = c + 1; end
      @(posedge clock); #1;
      r.cyc = c + 1;
      if (retired != r0 || halted || fault) r.done = 1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic compare(input string tag, input exp_t e, input res_t r);
    chk({tag, "_done"},     64'(r.done), 64'(1));
    chk({tag, "_cycles"},   64'(r.cyc), 64'(e.cyc));
    chk({tag, "_pc"},       64'(PC), 64'(e.pc));
    chk({tag, "_retired"},  64'(retired), 64'(e.ret));
    chk({tag, "_loaddata"}, 64'(load_data), 64'(e.ld));
    chk({tag, "_halted"},   64'(halted), 64'(e.h));
    chk({tag, "_fault"},    64'(fault), 64'(e.f));
    chk({tag, "_cause"},    64'(fault_cause), 64'(e.cause));
    chk({tag, "_rfwe_n"},   64'(r.rfwe_n), 64'(e.rfwe_cyc != 0));
    chk({tag, "_rfwe_cyc"}, 64'(r.rfwe_cyc), 64'(e.rfwe_cyc));
    chk({tag, "_dreq"},     64'(r.dseen), 64'(e.dseen));
    chk({tag, "_dwe"},      64'(r.weseen), 64'(e.weseen));
    chk({tag, "_dbus"},     64'(r.dbus_bad), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[12];
    instr_t t;
    exp_t   e;
    res_t   r;
    logic [31:0] pc0;
    int viol, k;

    // ins: iw dw ld st rw h sz alu npc drd ; exp: cyc pc ret ld h f cause rfwe_cyc dreq dwe
    vecs[0]  = '{mk_ins(0, 0, 0, 0, 1, 0, 2'd2, 32'h0, 32'h4, 32'h0),
                 mk_exp(3, 32'h4, 1, 32'h0, 0, 0, 2'd0, 3, 0, 0)};
    vecs[1]  = '{mk_ins(0, 2, 1, 0, 1, 0, 2'd2, 32'h100, 32'h4, 32'hDEADBEEF),
                 mk_exp(6, 32'h4, 1, 32'hDEADBEEF, 0, 0, 2'd0, 6, 1, 0)};
    vecs[2]  = '{mk_ins(0, 0, 0, 1, 0, 0, 2'd1, 32'h101, 32'h4, 32'h0),
                 mk_exp(2, 32'h0, 0, 32'h0, 0, 1, 2'd1, 0, 0, 0)};
    vecs[3]  = '{mk_ins(9, 0, 0, 0, 1, 0, 2'd2, 32'h0, 32'h4, 32'h0),
                 mk_exp(4, 32'h0, 0, 32'h0, 0, 1, 2'd2, 0, 0, 0)};
    vecs[4]  = '{mk_ins(3, 0, 0, 0, 1, 0, 2'd2, 32'h0, 32'h4, 32'h0),
                 mk_exp(6, 32'h4, 1, 32'h0, 0, 0, 2'd0, 6, 0, 0)};
    vecs[5]  = '{mk_ins(0, 9, 1, 0, 1, 0, 2'd2, 32'h100, 32'h4, 32'h1234),
                 mk_exp(6, 32'h0, 0, 32'h0, 0, 1, 2'd3, 0, 1, 0)};
    vecs[6]  = '{mk_ins(0, 0, 0, 0, 1, 0, 2'd2, 32'h0, 32'h6, 32'h0),
                 mk_exp(3, 32'h0, 0, 32'h0, 0, 1, 2'd1, 0, 0, 0)};
    vecs[7]  = '{mk_ins(0, 0, 0, 1, 0, 0, 2'd2, 32'h200, 32'h4, 32'h0),
                 mk_exp(4, 32'h4, 1, 32'h0, 0, 0, 2'd0, 0, 1, 1)};
    vecs[8]  = '{mk_ins(0, 0, 1, 0, 1, 0, 2'd3, 32'h102, 32'h4, 32'h0),
                 mk_exp(2, 32'h0, 0, 32'h0, 0, 1, 2'd1, 0, 0, 0)};
    vecs[9]  = '{mk_ins(0, 1, 1, 0, 1, 0, 2'd0, 32'h103, 32'h8, 32'h55),
                 mk_exp(5, 32'h8, 1, 32'h55, 0, 0, 2'd0, 5, 1, 0)};
    vecs[10] = '{mk_ins(1, 0, 1, 0, 1, 1, 2'd2, 32'h103, 32'h4, 32'h0),
                 mk_exp(3, 32'h0, 0, 32'h0, 1, 0, 2'd0, 0, 0, 0)};
    vecs[11] = '{mk_ins(0, 3, 1, 0, 1, 0, 2'd2, 32'h40, 32'hC, 32'hA5A5),
                 mk_exp(7, 32'hC, 1, 32'hA5A5, 0, 0, 2'd0, 7, 1, 0)};

    // Reset state, with stray acks during reset.
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_imem_req", 64'(imem_req), 64'(0));
    chk("rst_dmem_req", 64'(dmem_req), 64'(0));
    chk("rst_rfwe",     64'(rf_write_enable), 64'(0));
    chk("rst_pc",       64'(PC), 64'(RV));
    chk("rst_ir",       64'(instruction), 64'(32'h13));
    chk("rst_ld",       64'(load_data), 64'(0));
    chk("rst_retired",  64'(retired), 64'(0));
    chk("rst_flags",    64'({halted, fault, fault_cause}), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clock);
    chk("rst_fetch_req", 64'(imem_req), 64'(1));

    foreach (vecs[i]) begin
      do_reset();
      run_instr(vecs[i].in, r);
      compare($sformatf("vec%0d", i), vecs[i].ex, r);
    end

    // 23 instructions wrap the 4-bit counter to 7, then a halt.
    do_reset();
    for (int n = 0; n < 23; n++) begin
      t = mk_ins($urandom_range(0, 2), 0, 0, 0, 1, 0, 2'd2, 32'h0, m_pc + 32'd4, 32'h0);
      model_step(t, e);
      run_instr(t, r);
      compare($sformatf("seq%0d", n), e, r);
    end
    t = mk_ins(0, 0, 0, 0, 1, 1, 2'd2, 32'h0, m_pc + 32'd4, 32'h0);
    model_step(t, e);
    run_instr(t, r);
    compare("halt", e, r);
    viol = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      if (imem_req || dmem_req || rf_write_enable || !halted || fault) viol++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("halt_quiet",   64'(viol), 64'(0));
    chk("halt_retired", 64'(retired), 64'(7));

    // Reset while a load sits in MEMORY with ack present.
    do_reset();
    t = mk_ins(0, 0, 1, 0, 1, 0, 2'd2, 32'h100, 32'h4, 32'hCAFEF00D);
    model_step(t, e);
    run_instr(t, r);
    compare("preload", e, r);
    dec_load = 1'b1; dec_store = 1'b0; dec_halt = 1'b0; alu_result = 32'h104; next_pc = 32'h8;
    @(negedge clock); imem_ack = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); imem_ack = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rstmem_in_mem", 64'(dmem_req), 64'(1));
    reset = 1'b1; dmem_ack = 1'b1; imem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    chk("rstmem_dreq_forced", 64'(dmem_req), 64'(0));
    chk("rstmem_ireq_forced", 64'(imem_req), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0;
    chk("rstmem_pc",      64'(PC), 64'(RV));
    chk("rstmem_ld",      64'(load_data), 64'(0));
    chk("rstmem_retired", 64'(retired), 64'(0));
    @(negedge clock);
    chk("rstmem_fetch", 64'({imem_req, dmem_req}), 64'(2'b10));

    // Random instruction stream against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 99);
      t.h  = (k < 2);
      t.ld = (k >= 2 && k < 40);
      t.st = (k >= 40 && k < 65);
      t.rw = 1'($urandom_range(0, 1));
      t.sz = 2'($urandom_range(0, 3));
      t.alu = $urandom;
      if ($urandom_range(0, 19) != 0) t.alu[1:0] = 2'b00;
      t.npc = ($urandom_range(0, 39) == 0) ? 32'($urandom) : m_pc + 32'(4 * $urandom_range(1, 4));
      t.iwait = ($urandom_range(0, 39) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
      t.dwait = ($urandom_range(0, 39) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
      t.sd = $urandom; t.drd = $urandom; t.ird = $urandom;
      pc0 = m_pc;
      model_step(t, e);
      run_instr(t, r);
      compare($sformatf("rnd%0d", n), e, r);
      chk($sformatf("rnd%0d_ir", n), 64'(instruction), 64'(m_ir));
      chk($sformatf("rnd%0d_faddr", n), 64'(r.faddr), 64'(pc0));
      if (e.h || e.f) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32: address and data width.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- ACK_TIMEOUT, 255: maximum cycles a request may wait for acknowledge; 0 disables the timeout.
- COUNT_WIDTH, 32: width of the retired-instruction counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high.
- imem_req, out, 1: instruction fetch request.
- imem_addr, out, XLEN: fetch address, equal to PC.
- imem_ack, in, 1: fetch acknowledge.
- imem_rdata, in, 32: fetched instruction word.
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: 1 = store, 0 = load.
- dmem_addr, out, XLEN: data address (equal to alu_result).
- dmem_wdata, out, XLEN: store data (equal to store_data).
- dmem_ack, in, 1: data acknowledge.
- dmem_rdata, in, XLEN: load data.
- dec_load, in, 1: decoded load.
- dec_store, in, 1: decoded store.
- dec_reg_write, in, 1: decoded register write.
- dec_halt, in, 1: decoded ECALL/EBREAK.
- dec_size, in, 2: access size (00 byte, 01 half, 10 word).
- alu_result, in, XLEN: effective address or ALU result.
- store_data, in, XLEN: store operand.
- next_pc, in, XLEN: next PC computed by the datapath.
- instruction, out, 32: instruction register (IR).
- PC, out, XLEN: program counter register.
- load_data, out, XLEN: registered load data.
- rf_write_enable, out, 1: register-file write strobe.
- retired, out, COUNT_WIDTH: retired-instruction count.
- halted, out, 1: halt state reached.
- fault, out, 1: fault state reached.
- fault_cause, out, 2: 00 none, 01 misaligned, 10 imem timeout, 11 dmem timeout.

Function
REQ-003 The FSM SHALL have the states FETCH, EXECUTE, MEMORY, WRITEBACK, HALT and FAULT, encoded as the state register.
REQ-004 In FETCH, imem_req SHALL be 1; on the cycle with imem_req=1 and imem_ack=1, IR SHALL load imem_rdata and the FSM SHALL go to EXECUTE; otherwise it SHALL hold FETCH.
REQ-005 In EXECUTE, priority SHALL be dec_halt -> HALT, then (dec_load|dec_store) with misalignment -> FAULT (cause 01), then (dec_load|dec_store) -> MEMORY, else -> WRITEBACK.
REQ-006 An access SHALL be misaligned when dec_size=01 and alu_result[0]=1, or when dec_size=10 and alu_result[1:0]!=0; dec_size=11 SHALL be treated as word.
REQ-007 In MEMORY, dmem_req SHALL be 1 and dmem_we SHALL equal dec_store; on dmem_ack=1 a load SHALL capture dmem_rdata into load_data and the FSM SHALL go to WRITEBACK.
REQ-008 In WRITEBACK, the block SHALL, for exactly one cycle:
- drive rf_write_enable = dec_reg_write;
- load PC with next_pc;
- increment retired, wrapping modulo 2^COUNT_WIDTH;
- go to FETCH.
REQ-009 If next_pc[1:0]!=0 in WRITEBACK, the block SHALL instead go to FAULT (cause 01), leave PC and retired unchanged, and drive rf_write_enable = 0.
REQ-010 A wait counter SHALL clear on entry to FETCH or MEMORY and increment each cycle the request is held without acknowledge. When it reaches ACK_TIMEOUT (ACK_TIMEOUT != 0), the FSM SHALL go to FAULT with cause 10 (FETCH) or 11 (MEMORY).
REQ-011 imem_ack and dmem_ack SHALL be ignored whenever the matching request is 0.
REQ-012 An acknowledge arriving in the same cycle the timeout is reached SHALL win, and no fault SHALL be raised.
REQ-013 HALT and FAULT SHALL be terminal until reset, with all requests 0 and rf_write_enable 0; halted=1 only in HALT, and fault=1 only in FAULT.
REQ-014 Latency with zero-wait memory SHALL be 3 cycles for non-memory instructions and 4 cycles for loads/stores; each wait cycle SHALL add exactly 1.
REQ-015 imem_req, dmem_req and rf_write_enable SHALL be decoded from state and forced to 0 while reset=1.

Reset
REQ-016 On a clock edge with reset=1, the block SHALL set:
- state = FETCH;
- PC = RESET_VECTOR;
- IR = 32'h0000_0013;
- load_data = 0, retired = 0, wait counter = 0;
- halted = 0, fault = 0, fault_cause = 00.
REQ-017 Reset asserted mid-transaction SHALL abandon the access, and any acknowledge in the reset cycle SHALL be ignored.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADDI at 0, ack same cycle, next_pc=4 -> rf_write_enable pulses in cycle 3, PC=4, retired=1.
- Load word at addr 0x100, dmem_ack delayed 2 cycles, dmem_rdata=0xDEADBEEF -> load_data=0xDEADBEEF, 6 cycles total, dmem_we=0 throughout.
- Halfword store with alu_result=0x101 -> FAULT, fault_cause=01, dmem_req never asserted, retired unchanged.
- ACK_TIMEOUT=4, imem_ack held 0 -> FAULT with cause 10 after 4 FETCH cycles; ack arriving on the 4th wait cycle -> no fault.
- dec_halt with retired=7 -> halted=1, requests remain 0 for 20 cycles, retired stays 7.
- Reset asserted during MEMORY with dmem_ack=1 -> next state FETCH, PC=RESET_VECTOR, load_data=0.
